pc_next_unit: RTL and testbench
===============================

Name: pc_next_unit

Overview:
- Program-counter register and next-PC selection stage for the RV32I single-cycle core.
- Consumes the branch comparator result together with decoded control and immediate, then produces the PC for the next fetch.
- Detects misaligned control-transfer targets and holds in a trap-wait state until the trap controller acknowledges.
- One PC update per unstalled clock.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- TRAP_VECTOR, 32'h0000_0100, PC loaded when a misaligned-target trap is acknowledged.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- stall  input  1  hold PC this cycle (ignored in TRAP_WAIT).
- is_branch  input  1  current instruction is a conditional branch.
- is_jal  input  1  current instruction is JAL.
- is_jalr  input  1  current instruction is JALR.
- branch_cond  input  1  branch comparator result (taken when 1).
- imm  input  32  sign-extended B/J/I immediate.
- rs1_data  input  32  rs1 operand for JALR.
- trap_ack  input  1  trap controller accepts pending trap.
- pc  output  32  current PC (registered).
- pc_plus4  output  32  pc + 4, combinational (link value).
- redirect  output  1  combinational; high when this cycle commits a taken, aligned transfer.
- misalign_trap  output  1  registered; high while in TRAP_WAIT.
- trap_pc  output  32  registered; PC of the faulting instruction.
- trap_target  output  32  registered; offending misaligned target.

Behaviour:
- Reset (async, rst_n=0):
  - state=RUN, pc=RESET_VECTOR.
  - misalign_trap=0, trap_pc=0, trap_target=0.
  - pc_plus4=RESET_VECTOR+4, redirect=0.
- Arithmetic: all adds are 32-bit modulo 2^32; pc=32'hFFFF_FFFC steps to 32'h0000_0000.
- Target selection (combinational), priority jalr > jal > branch if several control inputs are high:
  - is_jalr: target=(rs1_data+imm) & ~32'h1, taken=1.
  - is_jal: target=pc+imm, taken=1.
  - is_branch: target=pc+imm, taken=branch_cond.
  - otherwise: taken=0, next=pc+4.
- Misaligned: taken=1 and target[1:0]!=2'b00. The JALR target's bit0 is already cleared, so only bit1 can fault.
- State RUN:
  - stall=1: pc holds, redirect=0, no state change.
  - stall=0, not taken: pc<=pc+4.
  - stall=0, taken and aligned: pc<=target, redirect=1.
  - stall=0, taken and misaligned: pc holds, trap_pc<=pc, trap_target<=target, misalign_trap<=1, state<=TRAP_WAIT, redirect=0.
- State TRAP_WAIT:
  - pc holds; stall and all control inputs are ignored; redirect=0.
  - trap_ack=1: pc<=TRAP_VECTOR, misalign_trap<=0, state<=RUN. Leaving TRAP_WAIT takes 1 cycle; the first TRAP_VECTOR fetch is visible the cycle after trap_ack.
  - trap_pc and trap_target keep their values until the next trap.
- trap_ack in RUN has no effect.
- A stall and a misaligned target in the same cycle: the stall wins; no trap is raised until the instruction actually commits.
- rst_n asserted in any state, including TRAP_WAIT: immediate return to reset values.
- Latency: registered outputs change one edge after the committing cycle; redirect and pc_plus4 are same-cycle.

Optional Feature:
- Macro: PC_NEXT_BRANCH_STATS_EN.
- Defined:
  - Adds output ports branch_count[31:0] and taken_count[31:0], both reset to 0.
  - branch_count increments on every committed (RUN, stall=0) cycle with is_branch=1 and is_jal=0 and is_jalr=0.
  - taken_count increments when such a branch also has branch_cond=1, including misaligned ones that trap.
  - Both counters saturate at 32'hFFFF_FFFF.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset release, no control, stall=0 for 3 cycles -> pc 0x0, 0x4, 0x8, 0xC; pc_plus4 tracks pc+4; redirect=0.
- pc=0x20, is_branch=1, branch_cond=1, imm=0xFFFF_FFF0 -> redirect=1, next pc=0x10. Same with branch_cond=0 -> next pc=0x24.
- pc=0x40, is_jalr=1, rs1_data=0x1001, imm=0x4 -> next pc=0x1004 (bit0 cleared). Same with rs1_data=0x1003 -> target 0x1006 misaligned: misalign_trap=1, trap_pc=0x40, trap_target=0x1006, pc stays 0x40.
- In TRAP_WAIT, hold trap_ack=0 for 3 cycles while toggling stall and is_jal -> pc frozen at 0x40. Then trap_ack=1 -> next cycle pc=0x100, misalign_trap=0.
- pc=0xFFFF_FFFC, no control -> next pc=0x0. stall=1 with is_jal=1, imm=0x2 -> pc held, no trap raised.
- With PC_NEXT_BRANCH_STATS_EN: 5 branches (3 taken, one stalled for 2 cycles before commit) -> branch_count=5, taken_count=3. Async reset mid-run -> both counters 0 and pc=RESET_VECTOR immediately.

Source files
------------

// File: rtl/pc_next_unit.sv
// Program-counter register and next-PC selection for the RV32I single-cycle core.
// Optional branch statistics counters are enabled with `define PC_NEXT_BRANCH_STATS_EN.
module pc_next_unit #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        is_branch,
   input  logic        is_jal,
   input  logic        is_jalr,
   input  logic        branch_cond,
   input  logic [31:0] imm,
   input  logic [31:0] rs1_data,
   input  logic        trap_ack,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        redirect,
   output logic        misalign_trap,
   output logic [31:0] trap_pc,
   output logic [31:0] trap_target
`ifdef PC_NEXT_BRANCH_STATS_EN
   ,
   output logic [31:0] branch_count,
   output logic [31:0] taken_count
`endif
);

   typedef enum logic {
      ST_RUN,
      ST_TRAP_WAIT
   } state_t;

   state_t      r_state;
   logic [31:0] r_pc;
   logic        r_misalign_trap;
   logic [31:0] r_trap_pc;
   logic [31:0] r_trap_target;

   logic [31:0] w_pc_plus4;
   logic [31:0] w_jalr_sum;
   logic [31:0] w_target;
   logic        w_taken;
   logic        w_misalign;
   logic        w_commit;

   assign w_pc_plus4 = r_pc + 32'd4;
   assign w_jalr_sum = rs1_data + imm;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      w_target = r_pc + imm;
      w_taken  = 1'b0;
      if (is_jalr) begin
         w_target = w_jalr_sum & ~32'h1;
         w_taken  = 1'b1;
      end else if (is_jal) begin
         w_taken  = 1'b1;
      end else if (is_branch) begin
         w_taken  = branch_cond;
      end
   end

   // A stalled instruction has not committed, so it can neither redirect nor trap.
   assign w_commit   = (r_state == ST_RUN) && !stall;
   assign w_misalign = w_taken && (w_target[1:0] != 2'b00);

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state         <= ST_RUN;
         r_pc            <= RESET_VECTOR;
         r_misalign_trap <= 1'b0;
         r_trap_pc       <= 32'h0;
         r_trap_target   <= 32'h0;
      end else begin
         case (r_state)
            ST_RUN: begin
               if (w_commit) begin
                  if (w_misalign) begin
                     r_trap_pc       <= r_pc;
                     r_trap_target   <= w_target;
                     r_misalign_trap <= 1'b1;
                     r_state         <= ST_TRAP_WAIT;
                  end else if (w_taken) begin
                     r_pc <= w_target;
                  end else begin
                     r_pc <= w_pc_plus4;
                  end
               end
            end
            ST_TRAP_WAIT: begin
               if (trap_ack) begin
                  r_pc            <= TRAP_VECTOR;
                  r_misalign_trap <= 1'b0;
                  r_state         <= ST_RUN;
               end
            end
            default: r_state <= ST_RUN;
         endcase
      end
   end

   assign pc            = r_pc;
   assign pc_plus4      = w_pc_plus4;
   assign redirect      = w_commit && w_taken && !w_misalign;
   assign misalign_trap = r_misalign_trap;
   assign trap_pc       = r_trap_pc;
   assign trap_target   = r_trap_target;

`ifdef PC_NEXT_BRANCH_STATS_EN
   logic [31:0] r_branch_count;
   logic [31:0] r_taken_count;
   logic        w_branch_commit;

   // Only a pure conditional branch counts; jal/jalr take priority when mixed in.
   assign w_branch_commit = w_commit && is_branch && !is_jal && !is_jalr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_branch_count <= 32'h0;
         r_taken_count  <= 32'h0;
      end else if (w_branch_commit) begin
         if (r_branch_count != 32'hFFFF_FFFF) r_branch_count <= r_branch_count + 32'd1;
         if (branch_cond && (r_taken_count != 32'hFFFF_FFFF)) r_taken_count <= r_taken_count + 32'd1;
      end
   end

   assign branch_count = r_branch_count;
   assign taken_count  = r_taken_count;
`endif

endmodule

// File: tb/tb_pc_next_unit.sv
// Self-checking bench for pc_next_unit: directed test-plan steps plus a randomized
// phase, all compared against a behavioural model of the next-PC rules.
module tb_pc_next_unit;

   localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
   localparam logic [31:0] TRAP_VECTOR  = 32'h0000_0100;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall, is_branch, is_jal, is_jalr, branch_cond, trap_ack;
   logic [31:0] imm, rs1_data;
   logic [31:0] pc, pc_plus4, trap_pc, trap_target;
   logic        redirect, misalign_trap;
`ifdef PC_NEXT_BRANCH_STATS_EN
   logic [31:0] branch_count, taken_count;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state
   logic [31:0] m_pc, m_trap_pc, m_trap_target;
   logic        m_in_trap;
   longint      m_branches, m_takens;

   always #5 clk = ~clk;

   pc_next_unit #(
      .RESET_VECTOR(RESET_VECTOR),
      .TRAP_VECTOR (TRAP_VECTOR)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .stall        (stall),
      .is_branch    (is_branch),
      .is_jal       (is_jal),
      .is_jalr      (is_jalr),
      .branch_cond  (branch_cond),
      .imm          (imm),
      .rs1_data     (rs1_data),
      .trap_ack     (trap_ack),
      .pc           (pc),
      .pc_plus4     (pc_plus4),
      .redirect     (redirect),
      .misalign_trap(misalign_trap),
      .trap_pc      (trap_pc),
      .trap_target  (trap_target)
`ifdef PC_NEXT_BRANCH_STATS_EN
      ,
      .branch_count (branch_count),
      .taken_count  (taken_count)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pc          = RESET_VECTOR;
      m_trap_pc     = 32'h0;
      m_trap_target = 32'h0;
      m_in_trap     = 1'b0;
      m_branches    = 0;
      m_takens      = 0;
   endtask

   task automatic check_regs(input string tag);
      check({tag, ".pc"}, pc, m_pc);
      check({tag, ".misalign_trap"}, {31'h0, misalign_trap}, {31'h0, m_in_trap});
      check({tag, ".trap_pc"}, trap_pc, m_trap_pc);
      check({tag, ".trap_target"}, trap_target, m_trap_target);
`ifdef PC_NEXT_BRANCH_STATS_EN
      check({tag, ".branch_count"}, branch_count, 32'(m_branches));
      check({tag, ".taken_count"}, taken_count, 32'(m_takens));
`endif
   endtask

   // One clock: called at a falling edge, returns at the next falling edge.
   task automatic step(input string tag, input logic s, input logic br, input logic jl,
                       input logic jr, input logic cond, input logic [31:0] im,
                       input logic [31:0] r1, input logic ack);
      logic [31:0] tgt;
      logic        tk, mis, commits;
      stall = s; is_branch = br; is_jal = jl; is_jalr = jr;
      branch_cond = cond; imm = im; rs1_data = r1; trap_ack = ack;
      #1;
      if (jr)      begin tgt = (r1 + im) & 32'hFFFF_FFFE; tk = 1'b1; end
      else if (jl) begin tgt = m_pc + im; tk = 1'b1; end
      else if (br) begin tgt = m_pc + im; tk = cond; end
      else         begin tgt = m_pc + 32'd4; tk = 1'b0; end
      mis     = tk && (tgt % 4 != 0);
      commits = !m_in_trap && !s;
      check({tag, ".pc_plus4"}, pc_plus4, m_pc + 32'd4);
      check({tag, ".redirect"}, {31'h0, redirect}, {31'h0, commits && tk && !mis});
      @(posedge clk);
      if (m_in_trap) begin
         if (ack) begin m_pc = TRAP_VECTOR; m_in_trap = 1'b0; end
      end else if (!s) begin
         if (br && !jl && !jr) begin
            if (m_branches < 64'hFFFF_FFFF) m_branches++;
            if (cond && m_takens < 64'hFFFF_FFFF) m_takens++;
         end
         if (mis) begin
            m_in_trap = 1'b1; m_trap_pc = m_pc; m_trap_target = tgt;
         end else begin
            m_pc = tk ? tgt : m_pc + 32'd4;
         end
      end
      #1;
      check_regs(tag);
      @(negedge clk);
   endtask

   task automatic idle(input string tag);
      step(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
   endtask

   task automatic jal_to(input string tag, input logic [31:0] dest);
      step(tag, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, dest - m_pc, 32'h0, 1'b0);
   endtask

   task automatic async_reset(input string tag);
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      check({tag, ".pc"}, pc, RESET_VECTOR);
      check_regs(tag);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; stall = 1'b0; is_branch = 1'b0; is_jal = 1'b0; is_jalr = 1'b0;
      branch_cond = 1'b0; imm = 32'h0; rs1_data = 32'h0; trap_ack = 1'b0;
      model_reset();
      @(negedge clk);
      #1;
      check("reset.pc", pc, 32'h0);
      check("reset.pc_plus4", pc_plus4, 32'h4);
      check("reset.redirect", {31'h0, redirect}, 32'h0);
      check_regs("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Sequential fetch after reset release
      idle("seq0"); check("seq0.pc_const", pc, 32'h4);
      idle("seq1"); check("seq1.pc_const", pc, 32'h8);
      idle("seq2"); check("seq2.pc_const", pc, 32'hC);

      // Conditional branch taken backwards / not taken
      jal_to("to20a", 32'h20);
      step("br_taken", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFF0, 32'h0, 1'b0);
      check("br_taken.pc_const", pc, 32'h10);
      jal_to("to20b", 32'h20);
      step("br_not", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFF0, 32'h0, 1'b0);
      check("br_not.pc_const", pc, 32'h24);

      // JALR aligned (bit0 cleared) then misaligned trap
      jal_to("to40a", 32'h40);
      step("jalr_ok", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h4, 32'h1001, 1'b0);
      check("jalr_ok.pc_const", pc, 32'h1004);
      jal_to("to40b", 32'h40);
      step("jalr_mis", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h4, 32'h1003, 1'b0);
      check("jalr_mis.pc_const", pc, 32'h40);
      check("jalr_mis.trap_const", {31'h0, misalign_trap}, 32'h1);
      check("jalr_mis.trap_pc_const", trap_pc, 32'h40);
      check("jalr_mis.trap_tgt_const", trap_target, 32'h1006);

      // TRAP_WAIT ignores stall and control until acknowledged
      step("tw0", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h8, 32'h0, 1'b0);
      step("tw1", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h8, 32'h0, 1'b0);
      step("tw2", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h8, 32'h0, 1'b0);
      check("tw2.pc_const", pc, 32'h40);
      step("tw_ack", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h8, 32'h0, 1'b1);
      check("tw_ack.pc_const", pc, 32'h100);
      check("tw_ack.trap_const", {31'h0, misalign_trap}, 32'h0);
      check("tw_ack.keep_tgt", trap_target, 32'h1006);
      step("ack_in_run", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
      check("ack_in_run.pc_const", pc, 32'h104);

      // Wraparound, and stall beats a misaligned target
      jal_to("to_top", 32'hFFFF_FFFC);
      idle("wrap"); check("wrap.pc_const", pc, 32'h0);
      step("stall_mis", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h2, 32'h0, 1'b0);
      check("stall_mis.pc_const", pc, 32'h0);
      check("stall_mis.trap_const", {31'h0, misalign_trap}, 32'h0);

      // Async reset while in TRAP_WAIT
      step("trap_again", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h2, 1'b0);
      check("trap_again.trap_const", {31'h0, misalign_trap}, 32'h1);
      async_reset("rst_in_trap");
      check("rst_in_trap.trap_const", {31'h0, misalign_trap}, 32'h0);

`ifdef PC_NEXT_BRANCH_STATS_EN
      // Five branches, three taken, one stalled twice before commit
      step("st_b1", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h8, 32'h0, 1'b0);
      step("st_b2", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h8, 32'h0, 1'b0);
      step("st_s1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h8, 32'h0, 1'b0);
      step("st_s2", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h8, 32'h0, 1'b0);
      step("st_b3", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h8, 32'h0, 1'b0);
      step("st_b4", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h8, 32'h0, 1'b0);
      step("st_b5", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h8, 32'h0, 1'b0);
      check("stats.branch_const", branch_count, 32'd5);
      check("stats.taken_const", taken_count, 32'd3);
      async_reset("stats_rst");
      check("stats_rst.branch_const", branch_count, 32'd0);
      check("stats_rst.taken_const", taken_count, 32'd0);
`endif

      // Randomized phase against the model
      for (int i = 0; i < 300; i++) begin
         logic [31:0] r_imm;
         r_imm = $urandom_range(0, 3) != 0 ? ($urandom & 32'hFFFF_FFFC) : $urandom;
         step("rand", ($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom_range(0, 3) == 0),
              1'($urandom_range(0, 4) == 0), 1'($urandom), r_imm, $urandom,
              1'($urandom_range(0, 2) == 0));
         if (i == 150) async_reset("rand_rst");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
